// File: rtl/led_pwm_driver.sv
// RGB PWM driver fed by a 3-bit colour code. Each channel's duty ramps toward
// its target by at most STEP once per PWM period, so colour changes cross-fade.
module led_pwm_driver #(
  parameter int W    = 8,
  parameter int STEP = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [2:0]   colour,
  input  logic [W-1:0] brightness,
  output logic         led_r,
  output logic         led_g,
  output logic         led_b,
  output logic         period_tick,
  output logic         settled
);
  localparam logic [W-1:0] MAX    = {W{1'b1}};
  localparam logic [W-1:0] ONE    = W'(1);
  localparam logic [W:0]   STEP_E = (W+1)'(STEP);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] duty_q [3];
  logic [W-1:0] duty_d [3];
  logic [W-1:0] tgt_s  [3];
  logic [2:0]   led_q, led_d;
  logic         tick_q, tick_d;
  logic         settled_q, settled_d;

  // One ramp step toward tgt, done in W+1 bits so it never wraps.
  function automatic logic [W-1:0] step_duty(input logic [W-1:0] cur, input logic [W-1:0] tgt);
    logic [W:0]   cur_e;
    logic [W:0]   tgt_e;
    logic [W-1:0] res;
    cur_e = {1'b0, cur};
    tgt_e = {1'b0, tgt};
    if (cur_e < tgt_e) begin
      if (cur_e + STEP_E >= tgt_e) res = tgt;
      else                         res = cur + STEP_E[W-1:0];
    end else if (cur_e > tgt_e) begin
      if (cur_e <= tgt_e + STEP_E) res = tgt;
      else                         res = cur - STEP_E[W-1:0];
    end else begin
      res = cur;
    end
    return res;
  endfunction

  // Per-channel target from the colour bits.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      if (colour[i]) tgt_s[i] = brightness;
      else           tgt_s[i] = '0;
    end
  end

  // Next-state: counter, PWM compare, and duty ramp on the period wrap.
  always_comb begin
    cnt_d     = '0;
    led_d     = 3'b000;
    tick_d    = 1'b0;
    settled_d = settled_q;
    for (int i = 0; i < 3; i++) duty_d[i] = duty_q[i];
    if (enable) begin
      cnt_d  = cnt_q + ONE;
      tick_d = (cnt_q == MAX);
      for (int i = 0; i < 3; i++) led_d[i] = (cnt_q < duty_q[i]);
      if (cnt_q == MAX) begin
        settled_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
          duty_d[i] = step_duty(duty_q[i], tgt_s[i]);
          if (duty_d[i] != tgt_s[i]) settled_d = 1'b0;
          else                       settled_d = settled_d;
        end
      end else begin
        settled_d = settled_q;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      led_q     <= 3'b000;
      tick_q    <= 1'b0;
      settled_q <= 1'b1;
      for (int i = 0; i < 3; i++) duty_q[i] <= '0;
    end else begin
      cnt_q     <= cnt_d;
      led_q     <= led_d;
      tick_q    <= tick_d;
      settled_q <= settled_d;
      for (int i = 0; i < 3; i++) duty_q[i] <= duty_d[i];
    end
  end

  assign led_r       = led_q[0];
  assign led_g       = led_q[1];
  assign led_b       = led_q[2];
  assign period_tick = tick_q;
  assign settled     = settled_q;
endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver: directed ramps plus random segments, every cycle
// compared against an arithmetic model of counter, duties and outputs.
module tb_led_pwm_driver;
  localparam int W    = 8;
  localparam int STEP = 16;
  localparam int MAX  = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] colour = 3'b000;
  logic [7:0] brightness = 8'd0;
  logic       led_r, led_g, led_b, period_tick, settled;

  int n_vec = 0;
  int n_err = 0;
  int hi_r;

  int m_cnt = 0;
  int m_duty [3] = '{0, 0, 0};
  int m_led  [3] = '{0, 0, 0};
  int m_tick = 0;
  int m_set  = 1;

  always #5 clk = ~clk;

  led_pwm_driver #(.W(W), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .colour(colour), .brightness(brightness),
    .led_r(led_r), .led_g(led_g), .led_b(led_b), .period_tick(period_tick), .settled(settled)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference: what the outputs must be after one clock edge with these inputs.
  task automatic model_edge(input bit r, input bit en, input logic [2:0] c, input int b);
    int tgt;
    if (r) begin
      m_cnt = 0; m_tick = 0; m_set = 1;
      for (int x = 0; x < 3; x++) begin m_duty[x] = 0; m_led[x] = 0; end
    end else if (!en) begin
      m_cnt = 0; m_tick = 0;
      for (int x = 0; x < 3; x++) m_led[x] = 0;
    end else begin
      for (int x = 0; x < 3; x++) m_led[x] = (m_cnt < m_duty[x]) ? 1 : 0;
      m_tick = (m_cnt == MAX) ? 1 : 0;
      if (m_cnt == MAX) begin
        m_set = 1;
        for (int x = 0; x < 3; x++) begin
          tgt = c[x] ? b : 0;
          if (m_duty[x] < tgt)      m_duty[x] = (m_duty[x] + STEP > tgt) ? tgt : m_duty[x] + STEP;
          else if (m_duty[x] > tgt) m_duty[x] = (m_duty[x] - STEP < tgt) ? tgt : m_duty[x] - STEP;
          if (m_duty[x] != tgt) m_set = 0;
        end
      end
      m_cnt = (m_cnt + 1) % (MAX + 1);
    end
  endtask

  task automatic run(input int n, input bit r, input bit en, input logic [2:0] c, input int b);
    int exp_out;
    hi_r = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst = r; enable = en; colour = c; brightness = 8'(b);
      model_edge(r, en, c, b);
      @(posedge clk);
      #1;
      exp_out = m_led[2]*16 + m_led[1]*8 + m_led[0]*4 + m_tick*2 + m_set;
      check("outs{b,g,r,tick,settled}", int'({led_b, led_g, led_r, period_tick, settled}), exp_out);
      if (led_r) hi_r++;
    end
  endtask

  initial begin
    // reset, then red ramp to full
    run(3, 1'b1, 1'b1, 3'b001, 255);
    run(256, 1'b0, 1'b1, 3'b001, 255);
    run(256, 1'b0, 1'b1, 3'b001, 255);
    check("red_first_period_high", hi_r, 16);
    run(14*256, 1'b0, 1'b1, 3'b001, 255);
    run(256, 1'b0, 1'b1, 3'b001, 255);
    check("red_full_period_high", hi_r, 255);
    // mid-period switch to green, cross-fade
    run(100, 1'b0, 1'b1, 3'b001, 255);
    run(156, 1'b0, 1'b1, 3'b010, 255);
    run(15*256, 1'b0, 1'b1, 3'b010, 255);
    run(256, 1'b0, 1'b1, 3'b010, 255);
    check("red_faded_out_high", hi_r, 0);
    // enable low holds everything at zero
    run(100, 1'b0, 1'b0, 3'b010, 255);
    run(300, 1'b0, 1'b1, 3'b010, 255);
    // white at brightness 40, then fade to 0
    run(2, 1'b1, 1'b1, 3'b111, 40);
    run(3*256, 1'b0, 1'b1, 3'b111, 40);
    run(256, 1'b0, 1'b1, 3'b111, 40);
    check("white40_red_high", hi_r, 40);
    run(3*256, 1'b0, 1'b1, 3'b111, 0);
    run(256, 1'b0, 1'b1, 3'b111, 0);
    check("white0_red_high", hi_r, 0);
    // reset mid-ramp on blue
    run(2, 1'b1, 1'b1, 3'b100, 255);
    run(3*256 + 50, 1'b0, 1'b1, 3'b100, 255);
    run(1, 1'b1, 1'b1, 3'b100, 255);
    run(2*256, 1'b0, 1'b1, 3'b100, 255);
    // random segments
    for (int s = 0; s < 80; s++) begin
      run($urandom_range(1, 600), ($urandom_range(0, 19) == 0), ($urandom_range(0, 5) != 0),
          3'($urandom_range(0, 7)), $urandom_range(0, 255));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/led_pwm_driver.md
Name: led_pwm_driver

Overview:
Consumer end of the 3-bit colour interface produced by the LED colour-cycler, driven by its `colour` output. Maps `colour` bits to red/green/blue channels and drives three PWM LED outputs. Ramps each channel's duty linearly toward its target, one step per PWM period, so colour changes cross-fade instead of snapping. Sits between the colour-cycler and the board's RGB LED pins.

Parameters:
W, 8, PWM counter and duty width; the period is 2^W clock cycles.
STEP, 16, maximum duty change per channel per PWM period (1..2^W-1).

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
enable  input  1  run PWM; when low, the counter and outputs are held
colour  input  3  colour code: bit0=red, bit1=green, bit2=blue; 0=off, 7=white
brightness  input  W  target duty for every channel whose colour bit is set
led_r  output  1  red PWM output, registered
led_g  output  1  green PWM output, registered
led_b  output  1  blue PWM output, registered
period_tick  output  1  one-cycle pulse marking the end of each PWM period, registered
settled  output  1  high when all duties equal their targets, registered

Behaviour:
- Reset (rst=1 at a clk edge, overriding everything else):
  - cnt=0 and duty_r/g/b=0.
  - led_r/g/b=0, period_tick=0, settled=1.
- enable=0, every edge:
  - cnt forced to 0.
  - led_r/g/b=0 and period_tick=0.
  - Duties and settled hold their values.
- enable=1, every edge:
  - cnt <= cnt+1, wrapping from MAX=2^W-1 to 0.
  - led_x <= (cnt < duty_x), evaluated with pre-edge values. This gives one cycle of latency from counter to pin.
  - duty=0 means always off. duty=MAX means on MAX of 2^W cycles, so 100% duty is never reached.
  - period_tick <= (cnt == MAX).
- Duty update, only on an enabled edge where cnt==MAX:
  - Sample colour and brightness. target_x = colour[x] ? brightness : 0.
  - If duty_x < target_x: duty_x <= min(duty_x+STEP, target_x).
  - If duty_x > target_x: duty_x <= max(duty_x-STEP, target_x).
  - Otherwise duty_x holds.
  - Compute in W+1 bits; no overflow or underflow wrap is permitted.
  - The new duty takes effect from the first cycle of the next period (cnt=0).
  - settled <= (all three updated duties equal their targets).
- Input sampling:
  - colour and brightness changes mid-period are ignored until the next wrap. No glitch within a period.
  - colour=7 is legal (white).
  - A change that reverses an in-progress ramp redirects it at the next wrap, stepping from the current duty.
- Reset mid-ramp: duties return to 0 immediately. The next ramp starts from 0.
- enable dropped mid-period: the period restarts at cnt=0 when enable rises again. The duty update for the aborted period is skipped.
- All state is on clk. There is no combinational path from inputs to outputs.

Test Plan:
1. Reset with W=8, STEP=16, enable=1 -> led_r/g/b=0, period_tick=0, settled=1 throughout reset; cnt starts at 0 on release.
2. After reset, colour=3'b001, brightness=255:
   - After the 1st wrap: duty_r=16 and led_r high for exactly 16 cycles of the next period.
   - Duty climbs 32, 48, ... and clamps at 255 on the 16th wrap.
   - settled=0 until that wrap, then 1.
   - led_g and led_b stay 0.
3. From a settled duty_r=255, switch colour to 3'b010 mid-period:
   - No change until the wrap.
   - duty_r then falls 239, 223, ... and duty_g rises 16, 32, ... in the same periods.
   - Both reach their targets on the 16th wrap.
4. period_tick pulses exactly once every 256 enabled cycles, one cycle after cnt==255. enable low for 100 cycles -> no tick, LEDs 0, duties unchanged.
5. colour=3'b111, brightness=40 from reset:
   - Duties go 16, 32, 40 on three successive wraps for all channels; the 40 is clamped, not 48.
   - Then brightness=0 -> duties go 24, 8, 0.
6. Assert rst mid-ramp (duty_b=48) -> next edge all outputs 0, duty 0, settled 1. On release, the ramp restarts from 16 after the first wrap.
